// File: rtl/dir_listing_buffer_if.sv
// Bus bundle for the directory-listing store: scanner push,
// OSD character fetch and loader selection.
interface dir_listing_buffer_if;
  logic        scan_start;
  logic        ent_valid;
  logic        ent_ready;
  logic [87:0] ent_name;
  logic        ent_dir;
  logic [31:0] ent_cluster;
  logic [31:0] ent_size;
  logic        overflow;
  logic [7:0]  dir_row;
  logic [3:0]  dir_col;
  logic [7:0]  dir_chr;
  logic [5:0]  dir_len;
  logic        file_selected;
  logic [7:0]  file_index;
  logic        sel_valid;
  logic [31:0] sel_cluster;
  logic [31:0] sel_size;
  logic        sel_dir;

  modport master (
    output scan_start, ent_valid, ent_name, ent_dir,
    output ent_cluster, ent_size, dir_row, dir_col,
    output file_selected, file_index,
    input  ent_ready, overflow, dir_chr, dir_len,
    input  sel_valid, sel_cluster, sel_size, sel_dir
  );

  modport slave (
    input  scan_start, ent_valid, ent_name, ent_dir,
    input  ent_cluster, ent_size, dir_row, dir_col,
    input  file_selected, file_index,
    output ent_ready, overflow, dir_chr, dir_len,
    output sel_valid, sel_cluster, sel_size, sel_dir
  );
endinterface

// File: rtl/dir_listing_buffer.sv
// Directory-listing store: formats 8.3 entries into 16-char rows,
// serves OSD character fetches and returns selected entry metadata.
module dir_listing_buffer #(
  parameter int MAX_ENTRIES = 32
) (
  input logic                 clk,
  input logic                 reset,
  dir_listing_buffer_if.slave bus
);
  localparam int AW = $clog2(MAX_ENTRIES);
  localparam logic [5:0] MAXL = 6'(MAX_ENTRIES);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e        state_q;
  logic [3:0]    col_q;
  logic [AW-1:0] wrow_q;
  logic [87:0]   name_q;
  logic          dir_q;
  logic [5:0]    len_q;
  logic          ovf_q;
  logic          rdy_q;
  logic [7:0]    chr_q;
  logic          pend_q;
  logic [AW-1:0] sidx_q;
  logic          selv_q;
  logic [31:0]   selc_q;
  logic [31:0]   sels_q;
  logic          seld_q;

  logic [7:0]  chr_ram [0:MAX_ENTRIES*16-1];
  logic [64:0] meta_ram [0:MAX_ENTRIES-1];

  logic          accept;
  logic          full;
  logic          take;
  logic [AW-1:0] trow;
  logic [127:0]  nm_pad;
  logic [3:0]    bidx;
  logic [7:0]    wbyte;
  logic          ext_blank;

  // scan_start may restart the listing even mid-write
  assign accept = bus.ent_valid & (rdy_q | bus.scan_start);
  assign full   = !bus.scan_start && (len_q == MAXL);
  assign take   = accept & !full;
  assign trow   = bus.scan_start ? '0 : len_q[AW-1:0];

  assign nm_pad    = {40'd0, name_q};
  assign ext_blank = (name_q[87:64] == 24'h202020);

  always_comb begin
    bidx  = (col_q <= 4'd8) ? col_q - 4'd1 : col_q - 4'd2;
    wbyte = nm_pad[{bidx, 3'b000} +: 8];
    unique case (1'b1)
      col_q == 4'd0:  wbyte = 8'h20;
      col_q == 4'd9:  wbyte = ext_blank ? 8'h20 : 8'h2E;
      col_q == 4'd13: wbyte = dir_q ? 8'h3C : 8'h20;
      col_q == 4'd14: wbyte = dir_q ? 8'h44 : 8'h20;
      col_q == 4'd15: wbyte = dir_q ? 8'h3E : 8'h20;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      wrow_q  <= '0;
      name_q  <= '0;
      dir_q   <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      if (bus.scan_start) begin
        len_q   <= '0;
        ovf_q   <= 1'b0;
        state_q <= IDLE;
        rdy_q   <= 1'b1;
      end else if (state_q == WRITE) begin
        col_q <= col_q + 4'd1;
        if (col_q == 4'd15) begin
          len_q   <= len_q + 6'd1;
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      end
      if (accept && full) ovf_q <= 1'b1;
      if (take) begin
        state_q <= WRITE;
        rdy_q   <= 1'b0;
        col_q   <= '0;
        wrow_q  <= trow;
        name_q  <= bus.ent_name;
        dir_q   <= bus.ent_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == WRITE) chr_ram[{wrow_q, col_q}] <= wbyte;
    if (take) meta_ram[trow] <= {bus.ent_dir, bus.ent_cluster, bus.ent_size};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chr_q  <= 8'h20;
      pend_q <= 1'b0;
      sidx_q <= '0;
      selv_q <= 1'b0;
      selc_q <= '0;
      sels_q <= '0;
      seld_q <= 1'b0;
    end else begin
      if (bus.dir_row < {2'b00, len_q})
        chr_q <= chr_ram[{bus.dir_row[AW-1:0], bus.dir_col}];
      else
        chr_q <= 8'h20;
      selv_q <= 1'b0;
      if (pend_q) begin
        pend_q <= 1'b0;
        selv_q <= 1'b1;
        {seld_q, selc_q, sels_q} <= meta_ram[sidx_q];
      end else if (bus.file_selected &&
                   bus.file_index < {2'b00, len_q}) begin
        pend_q <= 1'b1;
        sidx_q <= bus.file_index[AW-1:0];
      end
    end
  end

  assign bus.ent_ready   = rdy_q;
  assign bus.overflow    = ovf_q;
  assign bus.dir_chr     = chr_q;
  assign bus.dir_len     = len_q;
  assign bus.sel_valid   = selv_q;
  assign bus.sel_cluster = selc_q;
  assign bus.sel_size    = sels_q;
  assign bus.sel_dir     = seld_q;
endmodule

// File: tb/tb_dir_listing_buffer.sv
// Bench for dir_listing_buffer: cycle model of the listing plus
// directed literal checks on formatting, timing and selection.
module tb_dir_listing_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  dir_listing_buffer_if bus();

  dir_listing_buffer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [87:0] mk_name(input string s);
    logic [87:0] n;
    n = '0;
    for (int i = 0; i < 11; i++) n[i*8 +: 8] = s[i];
    return n;
  endfunction

  // Row text straight from the display rules
  function automatic logic [127:0] fmt(input logic [87:0] nm,
                                       input logic d);
    logic [127:0] r;
    r[7:0] = " ";
    for (int i = 0; i < 8; i++) r[(i+1)*8 +: 8] = nm[i*8 +: 8];
    r[72 +: 8] = (nm[87:64] == "   ") ? " " : ".";
    for (int i = 0; i < 3; i++) r[(10+i)*8 +: 8] = nm[(8+i)*8 +: 8];
    r[104 +: 8] = d ? "<" : " ";
    r[112 +: 8] = d ? "D" : " ";
    r[120 +: 8] = d ? ">" : " ";
    return r;
  endfunction

  // Model state: stored rows, count, write-busy countdown
  logic [127:0] rows [32];
  logic [64:0]  meta [32];
  int   mlen = 0, wleft = 0;
  bit   movf = 0, pend = 0, started = 0, acc;
  int   pidx = 0;
  logic [7:0]  e_chr;
  logic        e_ready, e_ovf, e_selv, e_dir;
  logic [5:0]  e_len;
  logic [31:0] e_cl, e_sz;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      mlen = 0; movf = 0; wleft = 0; pend = 0;
      e_chr = 8'h20; e_selv = 0; e_cl = 0; e_sz = 0; e_dir = 0;
    end else begin
      acc = bus.ent_valid && (wleft == 0 || bus.scan_start);
      if (int'(bus.dir_row) < mlen)
        e_chr = rows[bus.dir_row[4:0]][int'(bus.dir_col)*8 +: 8];
      else
        e_chr = 8'h20;
      e_selv = 0;
      if (pend) begin
        pend = 0; e_selv = 1;
        {e_dir, e_cl, e_sz} = meta[pidx];
      end else if (bus.file_selected && int'(bus.file_index) < mlen) begin
        pend = 1; pidx = int'(bus.file_index);
      end
      if (bus.scan_start) begin
        mlen = 0; movf = 0; wleft = 0;
      end else if (wleft > 0) begin
        wleft--;
        if (wleft == 0) mlen++;
      end
      if (acc) begin
        if (mlen == 32) movf = 1;
        else begin
          wleft = 16;
          rows[mlen] = fmt(bus.ent_name, bus.ent_dir);
          meta[mlen] = {bus.ent_dir, bus.ent_cluster, bus.ent_size};
        end
      end
    end
    e_ready = (wleft == 0);
    e_len = 6'(mlen);
    e_ovf = movf;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_ready", bus.ent_ready, e_ready);
      chk("m_len", bus.dir_len, e_len);
      chk("m_ovf", bus.overflow, e_ovf);
      chk("m_chr", bus.dir_chr, e_chr);
      chk("m_selv", bus.sel_valid, e_selv);
      chk("m_selc", bus.sel_cluster, e_cl);
      chk("m_sels", bus.sel_size, e_sz);
      chk("m_seld", bus.sel_dir, e_dir);
    end
  end

  task automatic offer(input string s, input logic d,
                       input logic [31:0] cl, input logic [31:0] sz);
    int n = 0;
    while (!bus.ent_ready && n < 40) begin n++; @(negedge clk); end
    chk("offer_ready", bus.ent_ready, 1'b1);
    bus.ent_name = mk_name(s); bus.ent_dir = d;
    bus.ent_cluster = cl; bus.ent_size = sz;
    bus.ent_valid = 1'b1;
    @(negedge clk);
    bus.ent_valid = 1'b0;
  endtask

  task automatic settle(output int lowcnt);
    lowcnt = 0;
    while (!bus.ent_ready && lowcnt < 40) begin
      lowcnt++; @(negedge clk);
    end
  endtask

  task automatic push(input string s, input logic d,
                      input logic [31:0] cl, input logic [31:0] sz);
    int lc;
    offer(s, d, cl, sz);
    settle(lc);
    chk("push_low16", lc, 16);
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] ch);
    bus.dir_row = 8'(r); bus.dir_col = 4'(c);
    @(negedge clk);
    ch = bus.dir_chr;
  endtask

  task automatic sel(input int idx);
    bus.file_selected = 1'b1; bus.file_index = 8'(idx);
    @(negedge clk);
    bus.file_selected = 1'b0;
    chk("sel_early", bus.sel_valid, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    string g, k;
    logic [7:0] ch;
    int lc, pulses;
    bus.scan_start = 0; bus.ent_valid = 0; bus.ent_name = '0;
    bus.ent_dir = 0; bus.ent_cluster = 0; bus.ent_size = 0;
    bus.dir_row = 0; bus.dir_col = 0;
    bus.file_selected = 0; bus.file_index = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_chr", bus.dir_chr, 8'h20);
    chk("rst_len", bus.dir_len, 6'd0);
    chk("rst_ready", bus.ent_ready, 1'b1);
    chk("rst_selv", bus.sel_valid, 1'b0);

    // first entry and its row text
    offer("GAME    ST ", 1'b0, 32'h123, 32'd737280);
    chk("game_busy", bus.ent_ready, 1'b0);
    settle(lc);
    chk("game_low16", lc, 16);
    chk("game_len", bus.dir_len, 6'd1);
    g = " GAME    .ST    ";
    for (int c = 0; c < 16; c++) begin
      rd(0, c, ch);
      chk("game_row", ch, g[c]);
    end

    push("DISKS      ", 1'b1, 32'h200, 32'd0);
    k = " DISKS       <D>";
    for (int c = 0; c < 16; c++) begin
      rd(1, c, ch);
      chk("disks_row", ch, k[c]);
    end
    rd(2, 1, ch);
    chk("row2_empty", ch, 8'h20);

    push("README  TXT", 1'b0, 32'h4567, 32'd1234);
    sel(2);
    chk("sel2_v", bus.sel_valid, 1'b1);
    chk("sel2_cl", bus.sel_cluster, 32'h4567);
    chk("sel2_sz", bus.sel_size, 32'd1234);
    chk("sel2_d", bus.sel_dir, 1'b0);
    sel(1);
    chk("sel1_v", bus.sel_valid, 1'b1);
    chk("sel1_d", bus.sel_dir, 1'b1);
    sel(3);
    chk("sel3_none", bus.sel_valid, 1'b0);
    // a held strobe gives one lookup only
    pulses = 0;
    bus.file_selected = 1'b1; bus.file_index = 8'd0;
    repeat (2) @(negedge clk);
    bus.file_selected = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.sel_valid) pulses++;
      @(negedge clk);
    end
    chk("sel_once", pulses, 1);
    chk("sel0_cl", bus.sel_cluster, 32'h123);

    // fill to capacity, then drop one
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    chk("scan_len0", bus.dir_len, 6'd0);
    for (int i = 0; i < 32; i++)
      push($sformatf("FILE%02d  DAT", i), 1'b0, 32'(i), 32'(i * 100));
    chk("full_len", bus.dir_len, 6'd32);
    offer("EXTRA   BIN", 1'b0, 32'h9, 32'h9);
    chk("ovf_ready", bus.ent_ready, 1'b1);
    chk("ovf_set", bus.overflow, 1'b1);
    chk("ovf_len", bus.dir_len, 6'd32);
    rd(31, 5, ch);
    chk("row31", ch, "3");
    rd(32, 1, ch);
    chk("row32", ch, 8'h20);
    rd(255, 1, ch);
    chk("row255", ch, 8'h20);
    sel(31);
    chk("sel31_sz", bus.sel_size, 32'd3100);
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    chk("clr_len", bus.dir_len, 6'd0);
    chk("clr_ovf", bus.overflow, 1'b0);

    // restart in the 8th write cycle
    offer("OLD     TMP", 1'b0, 32'h1, 32'h1);
    repeat (7) @(negedge clk);
    bus.scan_start = 1'b1;
    bus.ent_name = mk_name("NEW     IMG");
    bus.ent_dir = 1'b0; bus.ent_cluster = 32'h77; bus.ent_size = 32'h88;
    bus.ent_valid = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0; bus.ent_valid = 1'b0;
    chk("abort_len0", bus.dir_len, 6'd0);
    settle(lc);
    chk("abort_low16", lc, 16);
    chk("abort_len1", bus.dir_len, 6'd1);
    g = " NEW     .IMG   ";
    for (int c = 0; c < 16; c++) begin
      rd(0, c, ch);
      chk("new_row", ch, g[c]);
    end

    // reset mid-write with a lookup pending
    offer("LATE    DAT", 1'b0, 32'h5, 32'h6);
    bus.file_selected = 1'b1; bus.file_index = 8'd0;
    @(negedge clk);
    bus.file_selected = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.sel_valid) pulses++;
      @(negedge clk);
    end
    chk("rst_nosel", pulses, 0);
    chk("rst2_len", bus.dir_len, 6'd0);
    chk("rst2_ready", bus.ent_ready, 1'b1);
    chk("rst2_cl", bus.sel_cluster, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
